perf_monitor_unit: RTL and testbench

PERF_MONITOR_UNIT -- requirements
Module: perf_monitor_unit

---
 rtl/perf_monitor_unit.sv | 189 ++++++++++++++++++
 tb/tb_perf_monitor_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_unit.sv
// Performance monitor: programmable event counters with snapshot, overflow
// tracking and a masked interrupt, accessed through a simple req/ack
// register port.
module perf_monitor_unit #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_EVENTS    = 8,
  parameter int CORE_ID       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  reg_req,
  input  logic                  reg_we,
  input  logic [7:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic                  reg_ack,
  output logic                  overflow_irq
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                     w_access;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_ctrl_wr;
  logic                     w_ovf_wr;
  logic                     w_mask_wr;
  logic                     w_snap;
  logic                     w_clear;
  logic                     w_frozen;
  logic [NUM_COUNTERS-1:0]  w_evtsel_wr;
  logic [NUM_COUNTERS-1:0]  w_cnt_wr;
  logic [NUM_COUNTERS-1:0]  w_cond;
  logic [NUM_COUNTERS-1:0]  w_inc;
  logic [NUM_COUNTERS-1:0]  w_ovf_new;
  logic [31:0]              w_ev_ext;
  logic [31:0]              w_prev_ext;
  logic [31:0]              w_rd_data;

  logic [1:0]               r_ctrl;
  logic [NUM_COUNTERS-1:0]  r_ovf;
  logic [NUM_COUNTERS-1:0]  r_mask;
  logic [7:0]               r_evtsel [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] r_count  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] r_snap   [NUM_COUNTERS];
  logic [NUM_EVENTS-1:0]    r_events_prev;
  logic [31:0]              r_rdata;
  logic                     r_irq;

  // Handshake state register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and ack; the register access itself happens on the IDLE->ACK edge.
  always_comb begin
    w_state_next = r_state;
    w_access     = 1'b0;
    reg_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reg_req) begin
          w_state_next = S_ACK;
          w_access     = 1'b1;
        end
      end
      S_ACK: begin
        reg_ack      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Address decode into per-register write strobes and CTRL pulses.
  always_comb begin
    w_wr      = w_access & reg_we;
    w_rd      = w_access & ~reg_we;
    w_ctrl_wr = w_wr & (reg_addr == 8'h00);
    w_ovf_wr  = w_wr & (reg_addr == 8'h01);
    w_mask_wr = w_wr & (reg_addr == 8'h02);
    w_snap    = w_ctrl_wr & reg_wdata[2];
    w_clear   = w_ctrl_wr & reg_wdata[3];
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_evtsel_wr[i] = w_wr & (reg_addr == 8'(16 + i));
      w_cnt_wr[i]    = w_wr & (reg_addr == 8'(32 + i));
    end
  end

  // Event selection; events are zero-padded to 32 so an out-of-range index never fires.
  always_comb begin
    w_ev_ext                     = '0;
    w_prev_ext                   = '0;
    w_ev_ext[NUM_EVENTS-1:0]     = events;
    w_prev_ext[NUM_EVENTS-1:0]   = r_events_prev;
    w_frozen                     = r_ctrl[1] & (|r_ovf);
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_cond[i] = r_evtsel[i][6] ?
                  (w_ev_ext[r_evtsel[i][4:0]] & ~w_prev_ext[r_evtsel[i][4:0]]) :
                  w_ev_ext[r_evtsel[i][4:0]];
      w_inc[i]     = enable & r_ctrl[0] & r_evtsel[i][7] & w_cond[i] & ~w_frozen &
                     ~w_clear & ~w_cnt_wr[i];
      w_ovf_new[i] = w_inc[i] & (r_count[i] == {COUNTER_WIDTH{1'b1}});
    end
  end

  // Read mux; unmapped or out-of-range addresses return zero.
  always_comb begin
    w_rd_data = '0;
    case (reg_addr)
      8'h00: w_rd_data[1:0] = r_ctrl;
      8'h01: w_rd_data[NUM_COUNTERS-1:0] = r_ovf;
      8'h02: w_rd_data[NUM_COUNTERS-1:0] = r_mask;
      8'h03: w_rd_data = {8'(CORE_ID), 8'(NUM_COUNTERS), 8'(COUNTER_WIDTH), 8'(NUM_EVENTS)};
      default: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (reg_addr == 8'(16 + i)) w_rd_data[7:0] = r_evtsel[i];
          if (reg_addr == 8'(32 + i)) w_rd_data[COUNTER_WIDTH-1:0] = r_count[i];
          if (reg_addr == 8'(48 + i)) w_rd_data[COUNTER_WIDTH-1:0] = r_snap[i];
        end
      end
    endcase
  end

  // Software-programmed control, mask and event-select registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_mask <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) r_evtsel[i] <= '0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= reg_wdata[1:0];
      if (w_mask_wr) r_mask <= reg_wdata[NUM_COUNTERS-1:0];
      for (int i = 0; i < NUM_COUNTERS; i++)
        if (w_evtsel_wr[i]) r_evtsel[i] <= reg_wdata[7:0] & 8'hDF;
    end
  end

  // Overflow flags: W1C, with a fresh overflow winning over a clear of the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= '0;
    else        r_ovf <= (r_ovf & ~(w_ovf_wr ? reg_wdata[NUM_COUNTERS-1:0] : '0)) | w_ovf_new;
  end

  // Live counters and snapshots; clear-all beats software write beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_count[i] <= '0;
        r_snap[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (w_clear)          r_count[i] <= '0;
        else if (w_cnt_wr[i]) r_count[i] <= reg_wdata[COUNTER_WIDTH-1:0];
        else if (w_inc[i])    r_count[i] <= r_count[i] + COUNTER_WIDTH'(1);
        if (w_clear)          r_snap[i]  <= '0;
        else if (w_snap)      r_snap[i]  <= r_count[i];
      end
    end
  end

  // Edge-detect history, registered interrupt and captured read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_events_prev <= '0;
      r_irq         <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_events_prev <= events;
      r_irq         <= |(r_ovf & r_mask);
      if (w_access) r_rdata <= w_rd ? w_rd_data : '0;
    end
  end

  assign reg_rdata    = r_rdata;
  assign overflow_irq = r_irq;

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Directed bench for perf_monitor_unit: a register vector table followed by
// hand-written multi-cycle sequences for counting, overflow, freeze and reset.
module tb_perf_monitor_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  events;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        overflow_irq;

  int total;
  int bad;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  perf_monitor_unit #(
    .NUM_COUNTERS (4),
    .COUNTER_WIDTH(32),
    .NUM_EVENTS   (8),
    .CORE_ID      (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .events      (events),
    .reg_req     (reg_req),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .overflow_irq(overflow_irq)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One register access; ack must be high in the cycle after the request and low after that.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = data;
    @(posedge clk);
    #1;
    reg_req = 1'b0;
    reg_we  = 1'b0;
    checkOutput("ack_hi", {31'b0, reg_ack}, 32'd1);
    rdata = reg_rdata;
    @(posedge clk);
    #1;
    checkOutput("ack_lo", {31'b0, reg_ack}, 32'd0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] v;
    applyStimulus(1'b1, addr, data, v);
  endtask

  task automatic rdChk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    applyStimulus(1'b0, addr, 32'h0, v);
    checkOutput(name, v, exp);
  endtask

  initial begin
    logic [31:0] rv;
    logic [7:0]  zeroAddrs [15];
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    events    = '0;
    reg_req   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;

    vecs[0]  = '{1'b0, 8'h03, 32'h0,        32'h00042008};
    vecs[1]  = '{1'b1, 8'h02, 32'hFFFFFFFF, 32'h0};
    vecs[2]  = '{1'b0, 8'h02, 32'h0,        32'h0000000F};
    vecs[3]  = '{1'b1, 8'h10, 32'hFFFF00C3, 32'h0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,        32'h000000C3};
    vecs[5]  = '{1'b1, 8'h14, 32'h00000083, 32'h0};
    vecs[6]  = '{1'b0, 8'h14, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 8'h23, 32'h12345678, 32'h0};
    vecs[8]  = '{1'b0, 8'h23, 32'h0,        32'h12345678};
    vecs[9]  = '{1'b0, 8'h33, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 8'h05, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 8'h40, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 8'h00, 32'h0000000F, 32'h0};
    vecs[13] = '{1'b0, 8'h00, 32'h0,        32'h00000003};
    vecs[14] = '{1'b0, 8'h23, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 8'h00, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 8'h02, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 8'h10, 32'h0,        32'h0};
    vecs[18] = '{1'b0, 8'h10, 32'h0,        32'h0};

    tick(3);
    rst_n = 1'b1;
    checkOutput("rst_ack", {31'b0, reg_ack}, 32'd0);
    checkOutput("rst_irq", {31'b0, overflow_irq}, 32'd0);
    checkOutput("rst_rdata", reg_rdata, 32'h0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, rv);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d", i), rv, vecs[i].exp);
    end

    // Level-mode counting, then the same stimulus with enable low.
    wr(8'h10, 32'h83);
    wr(8'h00, 32'h1);
    enable = 1'b1;
    events = 8'h08;
    tick(10);
    events = 8'h00;
    rdChk("lvl_cnt", 8'h20, 32'd10);
    wr(8'h20, 32'h0);
    enable = 1'b0;
    events = 8'h08;
    tick(10);
    events = 8'h00;
    rdChk("lvl_dis", 8'h20, 32'd0);
    enable = 1'b1;
    wr(8'h10, 32'h0);

    // Edge-mode counting on a 3-high / 2-low pattern.
    wr(8'h11, 32'hC2);
    for (int k = 0; k < 4; k++) begin
      events = 8'h04;
      tick(3);
      events = 8'h00;
      tick(2);
    end
    rdChk("edge_cnt", 8'h21, 32'd4);
    wr(8'h11, 32'h0);

    // Event index beyond the event vector never counts.
    wr(8'h12, 32'h89);
    events = 8'hFF;
    tick(5);
    events = 8'h00;
    rdChk("idx_oor", 8'h22, 32'd0);
    wr(8'h12, 32'h0);

    // Wrap from all-ones, overflow flag and masked interrupt.
    wr(8'h02, 32'h4);
    wr(8'h22, 32'hFFFFFFFE);
    wr(8'h12, 32'h80);
    events = 8'h01;
    tick(1);
    checkOutput("irq_pre", {31'b0, overflow_irq}, 32'd0);
    tick(2);
    events = 8'h00;
    checkOutput("irq_set", {31'b0, overflow_irq}, 32'd1);
    rdChk("ovf_wrap_cnt", 8'h22, 32'd1);
    rdChk("ovf_reg", 8'h01, 32'h4);
    wr(8'h01, 32'h4);
    checkOutput("irq_clr", {31'b0, overflow_irq}, 32'd0);
    rdChk("ovf_clr", 8'h01, 32'h0);

    // A new overflow on the same edge as its W1C keeps the flag set.
    wr(8'h22, 32'hFFFFFFFF);
    events = 8'h01;
    tick(1);
    events = 8'h00;
    wr(8'h22, 32'hFFFFFFFF);
    events = 8'h01;
    wr(8'h01, 32'h4);
    events = 8'h00;
    rdChk("ovf_race", 8'h01, 32'h4);
    rdChk("ovf_race_cnt", 8'h22, 32'd1);

    // Software write to a counter beats its increment on the same edge.
    events = 8'h01;
    wr(8'h22, 32'h100);
    events = 8'h00;
    rdChk("wr_beats_inc", 8'h22, 32'h101);
    wr(8'h01, 32'hF);
    wr(8'h12, 32'h0);
    wr(8'h02, 32'h0);

    // Freeze on overflow, snapshot of held values, resume after OVF clear.
    wr(8'h00, 32'h3);
    wr(8'h10, 32'h80);
    wr(8'h11, 32'h81);
    wr(8'h20, 32'hFFFFFFFD);
    wr(8'h21, 32'h10);
    events = 8'h03;
    tick(6);
    events = 8'h00;
    rdChk("frz_c0", 8'h20, 32'h0);
    rdChk("frz_c1", 8'h21, 32'h13);
    rdChk("frz_ovf", 8'h01, 32'h1);
    wr(8'h00, 32'h7);
    rdChk("snap0", 8'h30, 32'h0);
    rdChk("snap1", 8'h31, 32'h13);
    events = 8'h03;
    tick(3);
    events = 8'h00;
    rdChk("frz_hold", 8'h21, 32'h13);
    events = 8'h03;
    wr(8'h01, 32'h1);
    events = 8'h00;
    rdChk("resume_c0", 8'h20, 32'h1);
    rdChk("resume_c1", 8'h21, 32'h14);
    rdChk("snap_static", 8'h31, 32'h13);

    // Snapshot captures the pre-increment value.
    events = 8'h02;
    wr(8'h00, 32'h5);
    events = 8'h00;
    rdChk("snap_pre", 8'h31, 32'h14);
    rdChk("snap_live", 8'h21, 32'h16);

    // Clear-all beats increment and snapshot.
    events = 8'h02;
    wr(8'h00, 32'h9);
    events = 8'h00;
    rdChk("clr_cnt", 8'h21, 32'h1);
    rdChk("clr_snap", 8'h31, 32'h0);
    rdChk("clr_c0", 8'h20, 32'h0);

    // Reset while counting and during an ACK cycle.
    wr(8'h02, 32'hF);
    wr(8'h23, 32'hFFFFFFFF);
    wr(8'h13, 32'h80);
    events = 8'h01;
    tick(2);
    checkOutput("irq_pre_rst", {31'b0, overflow_irq}, 32'd1);
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = 8'h03;
    @(posedge clk);
    #1;
    reg_req = 1'b0;
    checkOutput("ack_before_rst", {31'b0, reg_ack}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    events = 8'h00;
    checkOutput("rst2_ack", {31'b0, reg_ack}, 32'd0);
    checkOutput("rst2_irq", {31'b0, overflow_irq}, 32'd0);
    checkOutput("rst2_rdata", reg_rdata, 32'h0);
    zeroAddrs = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13,
                  8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33};
    for (int i = 0; i < 15; i++)
      rdChk($sformatf("rst2_reg%02h", zeroAddrs[i]), zeroAddrs[i], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
